// File: rtl/riscv_pipe_pkg.sv
// Shared encodings and stage-register layouts for the pipeline control path.
package riscv_pipe_pkg;

  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [2:0] alu_control;
    logic       alu_src;
    reg_addr_t  rs1;
    reg_addr_t  rs2;
    reg_addr_t  rd;
  } e_stage_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    reg_addr_t  rd;
  } m_stage_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    reg_addr_t  rd;
  } w_stage_t;

  // The younger producer (M) wins; x0 is hardwired zero and never forwarded.
  function automatic fwd_t fwd_sel(reg_addr_t rs, logic reg_write_m, reg_addr_t rd_m,
                                   logic reg_write_w, reg_addr_t rd_w);
    if (rs != '0 && reg_write_m && rd_m == rs) return FWD_MEM;
    if (rs != '0 && reg_write_w && rd_w == rs) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/ctrl_hazard_pipe_if.sv
// Decoder-side control inputs and hazard/stage outputs of the pipeline control block.
interface ctrl_hazard_pipe_if;
  import riscv_pipe_pkg::*;

  logic [1:0]  ResultSrcD;
  logic        MemWriteD;
  logic        ALUSrcD;
  logic        RegWriteD;
  logic        JumpD;
  logic        BranchD;
  logic [2:0]  ALUControlD;
  reg_addr_t   Rs1D;
  reg_addr_t   Rs2D;
  reg_addr_t   RdD;
  logic        ZeroE;

  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic        FlushE;
  logic [1:0]  ForwardAE;
  logic [1:0]  ForwardBE;
  logic        PCSrcE;
  logic        ALUSrcE;
  logic [2:0]  ALUControlE;
  logic        MemWriteM;
  logic [1:0]  ResultSrcW;
  logic        RegWriteW;
  reg_addr_t   RdW;

  modport master (
    output ResultSrcD, MemWriteD, ALUSrcD, RegWriteD, JumpD, BranchD,
           ALUControlD, Rs1D, Rs2D, RdD, ZeroE,
    input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, PCSrcE,
           ALUSrcE, ALUControlE, MemWriteM, ResultSrcW, RegWriteW, RdW
  );

  modport slave (
    input  ResultSrcD, MemWriteD, ALUSrcD, RegWriteD, JumpD, BranchD,
           ALUControlD, Rs1D, Rs2D, RdD, ZeroE,
    output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, PCSrcE,
           ALUSrcE, ALUControlE, MemWriteM, ResultSrcW, RegWriteW, RdW
  );

endinterface

// File: rtl/hazard_unit.sv
// Combinational load-use stall, control-flow flush and operand-forward selection.
module hazard_unit
  import riscv_pipe_pkg::*;
(
  input  logic [1:0] result_src_e,
  input  reg_addr_t  rs1_d,
  input  reg_addr_t  rs2_d,
  input  reg_addr_t  rs1_e,
  input  reg_addr_t  rs2_e,
  input  reg_addr_t  rd_e,
  input  logic       branch_e,
  input  logic       jump_e,
  input  logic       zero_e,
  input  logic       reg_write_m,
  input  reg_addr_t  rd_m,
  input  logic       reg_write_w,
  input  reg_addr_t  rd_w,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_d,
  output logic       flush_e,
  output logic       pc_src_e,
  output logic [1:0] forward_ae,
  output logic [1:0] forward_be
);

  logic lw_stall;

  // E holds a single instruction, so a load stall and a taken branch/jump cannot coincide.
  assign lw_stall = (result_src_e == RES_MEM) && (rd_e != '0) &&
                    ((rs1_d == rd_e) || (rs2_d == rd_e));
  assign pc_src_e = (branch_e & zero_e) | jump_e;

  assign stall_f  = lw_stall;
  assign stall_d  = lw_stall;
  assign flush_d  = pc_src_e;
  assign flush_e  = lw_stall | pc_src_e;

  assign forward_ae = fwd_sel(rs1_e, reg_write_m, rd_m, reg_write_w, rd_w);
  assign forward_be = fwd_sel(rs2_e, reg_write_m, rd_m, reg_write_w, rd_w);

endmodule

// File: rtl/ctrl_hazard_pipe.sv
// E/M/W control stage registers with hazard detection for a 5-stage in-order pipeline.
module ctrl_hazard_pipe
  import riscv_pipe_pkg::*;
(
  input logic               clk,
  input logic               reset,
  ctrl_hazard_pipe_if.slave bus
);

  e_stage_t e_d, e_q;
  m_stage_t m_q;
  w_stage_t w_q;

  logic       stall_f, stall_d, flush_d, flush_e, pc_src_e;
  logic [1:0] forward_ae, forward_be;

  assign e_d = '{reg_write:   bus.RegWriteD,
                 result_src:  bus.ResultSrcD,
                 mem_write:   bus.MemWriteD,
                 jump:        bus.JumpD,
                 branch:      bus.BranchD,
                 alu_control: bus.ALUControlD,
                 alu_src:     bus.ALUSrcD,
                 rs1:         bus.Rs1D,
                 rs2:         bus.Rs2D,
                 rd:          bus.RdD};

  // A flushed E slot becomes an all-zero bubble: no write, no store, no branch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= flush_e ? '0 : e_d;
      m_q <= '{reg_write:  e_q.reg_write,
               result_src: e_q.result_src,
               mem_write:  e_q.mem_write,
               rd:         e_q.rd};
      w_q <= '{reg_write:  m_q.reg_write,
               result_src: m_q.result_src,
               rd:         m_q.rd};
    end
  end

  hazard_unit u_hazard (
    .result_src_e (e_q.result_src),
    .rs1_d        (bus.Rs1D),
    .rs2_d        (bus.Rs2D),
    .rs1_e        (e_q.rs1),
    .rs2_e        (e_q.rs2),
    .rd_e         (e_q.rd),
    .branch_e     (e_q.branch),
    .jump_e       (e_q.jump),
    .zero_e       (bus.ZeroE),
    .reg_write_m  (m_q.reg_write),
    .rd_m         (m_q.rd),
    .reg_write_w  (w_q.reg_write),
    .rd_w         (w_q.rd),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .flush_d      (flush_d),
    .flush_e      (flush_e),
    .pc_src_e     (pc_src_e),
    .forward_ae   (forward_ae),
    .forward_be   (forward_be)
  );

  assign bus.StallF      = stall_f;
  assign bus.StallD      = stall_d;
  assign bus.FlushD      = flush_d;
  assign bus.FlushE      = flush_e;
  assign bus.PCSrcE      = pc_src_e;
  assign bus.ForwardAE   = forward_ae;
  assign bus.ForwardBE   = forward_be;
  assign bus.ALUSrcE     = e_q.alu_src;
  assign bus.ALUControlE = e_q.alu_control;
  assign bus.MemWriteM   = m_q.mem_write;
  assign bus.ResultSrcW  = w_q.result_src;
  assign bus.RegWriteW   = w_q.reg_write;
  assign bus.RdW         = w_q.rd;

endmodule

// File: tb/tb_ctrl_hazard_pipe.sv
// Scoreboard bench: instruction-level reference model predicts each cycle's control outputs.
module tb_ctrl_hazard_pipe;
  import riscv_pipe_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ctrl_hazard_pipe_if bus();
  ctrl_hazard_pipe dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    bit       rw;
    bit [1:0] rs;
    bit       mw;
    bit       jmp;
    bit       br;
    bit [2:0] alu;
    bit       asrc;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit [4:0] rd;
  } instr_t;

  typedef struct {
    int stallf, stalld, flushd, flushe, fa, fb, pcsrc;
    int alusrc, aluctl, mwm, rsw, rww, rdw;
  } exp_t;

  int checks = 0;
  int failures = 0;
  instr_t hist[$];   // [0]=W, [1]=M, [2]=E as seen during the current cycle
  exp_t   sb[$];
  bit     dummy;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic instr_t nop();
    instr_t i = '{default: 0};
    return i;
  endfunction

  function automatic instr_t mk_alu(bit [4:0] rd, bit [4:0] rs1, bit [4:0] rs2);
    instr_t i = nop();
    i.rw = 1; i.alu = 3'd2; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
    return i;
  endfunction

  function automatic instr_t mk_load(bit [4:0] rd, bit [4:0] rs1);
    instr_t i = nop();
    i.rw = 1; i.rs = 2'b01; i.asrc = 1; i.rd = rd; i.rs1 = rs1;
    return i;
  endfunction

  function automatic instr_t mk_store(bit [4:0] rd, bit [4:0] rs1, bit [4:0] rs2);
    instr_t i = nop();
    i.mw = 1; i.asrc = 1; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
    return i;
  endfunction

  function automatic instr_t mk_branch(bit [4:0] rs1, bit [4:0] rs2);
    instr_t i = nop();
    i.br = 1; i.alu = 3'd1; i.rs1 = rs1; i.rs2 = rs2;
    return i;
  endfunction

  function automatic instr_t mk_jump(bit [4:0] rd);
    instr_t i = nop();
    i.jmp = 1; i.rw = 1; i.rs = 2'b10; i.rd = rd;
    return i;
  endfunction

  function automatic bit [4:0] rand_reg();
    if ($urandom_range(0, 7) == 0) return 5'($urandom);
    return 5'($urandom_range(0, 3));
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    case ($urandom_range(0, 5))
      0, 1: begin i = mk_alu(rand_reg(), rand_reg(), rand_reg()); i.alu = 3'($urandom); i.asrc = 1'($urandom); end
      2:    i = mk_load(rand_reg(), rand_reg());
      3:    i = mk_store(rand_reg(), rand_reg(), rand_reg());
      4:    i = mk_branch(rand_reg(), rand_reg());
      default: i = mk_jump(rand_reg());
    endcase
    return i;
  endfunction

  // Operand comes from the nearest older instruction that writes a non-zero register.
  function automatic int fwd_model(bit [4:0] src, instr_t m, instr_t w);
    if (src == 0) return 0;
    if (m.rw && m.rd == src) return 2;
    if (w.rw && w.rd == src) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (3) hist.push_back(nop());
  endtask

  task automatic drive(input instr_t d, input bit zero);
    bus.ResultSrcD  = d.rs;
    bus.MemWriteD   = d.mw;
    bus.ALUSrcD     = d.asrc;
    bus.RegWriteD   = d.rw;
    bus.JumpD       = d.jmp;
    bus.BranchD     = d.br;
    bus.ALUControlD = d.alu;
    bus.Rs1D        = d.rs1;
    bus.Rs2D        = d.rs2;
    bus.RdD         = d.rd;
    bus.ZeroE       = zero;
  endtask

  task automatic issue(input instr_t d, input bit zero, output bit stalled);
    exp_t e;
    instr_t se, sm, sw;
    bit lu, pc;
    @(negedge clk);
    drive(d, zero);
    #1;
    se = hist[2]; sm = hist[1]; sw = hist[0];
    pc = (se.br && zero) || se.jmp;
    lu = (se.rs == 2'b01) && (se.rd != 0) && (d.rs1 == se.rd || d.rs2 == se.rd);
    e.stallf = lu;  e.stalld = lu;
    e.flushd = pc;  e.flushe = lu || pc;
    e.pcsrc  = pc;
    e.fa     = fwd_model(se.rs1, sm, sw);
    e.fb     = fwd_model(se.rs2, sm, sw);
    e.alusrc = se.asrc;
    e.aluctl = se.alu;
    e.mwm    = sm.mw;
    e.rsw    = sw.rs;
    e.rww    = sw.rw;
    e.rdw    = sw.rd;
    sb.push_back(e);
    void'(hist.pop_front());
    hist.push_back((lu || pc) ? nop() : d);
    stalled = lu;
  endtask

  task automatic go(input instr_t d, input bit zero);
    issue(d, zero, dummy);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_stallf"}, bus.StallF, 0);
    check({tag, "_stalld"}, bus.StallD, 0);
    check({tag, "_flushd"}, bus.FlushD, 0);
    check({tag, "_flushe"}, bus.FlushE, 0);
    check({tag, "_fwda"}, bus.ForwardAE, 0);
    check({tag, "_fwdb"}, bus.ForwardBE, 0);
    check({tag, "_pcsrc"}, bus.PCSrcE, 0);
    check({tag, "_alusrc"}, bus.ALUSrcE, 0);
    check({tag, "_aluctl"}, bus.ALUControlE, 0);
    check({tag, "_memwr"}, bus.MemWriteM, 0);
    check({tag, "_ressrcw"}, bus.ResultSrcW, 0);
    check({tag, "_regwrw"}, bus.RegWriteW, 0);
    check({tag, "_rdw"}, bus.RdW, 0);
  endtask

  // Monitor: compares every cycle's outputs against the oldest queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_stallf", bus.StallF, e.stallf);
        check("sb_stalld", bus.StallD, e.stalld);
        check("sb_flushd", bus.FlushD, e.flushd);
        check("sb_flushe", bus.FlushE, e.flushe);
        check("sb_fwda", bus.ForwardAE, e.fa);
        check("sb_fwdb", bus.ForwardBE, e.fb);
        check("sb_pcsrc", bus.PCSrcE, e.pcsrc);
        check("sb_alusrc", bus.ALUSrcE, e.alusrc);
        check("sb_aluctl", bus.ALUControlE, e.aluctl);
        check("sb_memwr", bus.MemWriteM, e.mwm);
        check("sb_ressrcw", bus.ResultSrcW, e.rsw);
        check("sb_regwrw", bus.RegWriteW, e.rww);
        check("sb_rdw", bus.RdW, e.rdw);
        check("stall_pcsrc_exclusive", int'(bus.StallF & bus.PCSrcE), 0);
      end
    end
  end

  initial begin
    instr_t cur;
    bit st;
    reset = 1'b1;
    drive(nop(), 1'b0);
    #3;
    check_zero("reset");
    #5;
    reset = 1'b0;
    model_reset();

    // load-use: one stall cycle, then the held instruction proceeds
    repeat (3) go(nop(), 0);
    go(mk_load(5, 1), 0);
    go(mk_alu(6, 5, 0), 0);
    check("lu_stallf", bus.StallF, 1);
    check("lu_stalld", bus.StallD, 1);
    check("lu_flushe", bus.FlushE, 1);
    go(mk_alu(6, 5, 0), 0);
    check("lu_release", bus.StallF, 0);

    // forward priority M over W
    repeat (3) go(nop(), 0);
    go(mk_alu(7, 1, 2), 0);
    go(mk_alu(7, 1, 2), 0);
    go(mk_alu(1, 7, 0), 0);
    go(nop(), 0);
    check("fwd_m_prio", bus.ForwardAE, 2);
    go(mk_alu(7, 1, 2), 0);
    go(mk_store(7, 0, 0), 0);
    go(mk_alu(1, 7, 0), 0);
    go(nop(), 0);
    check("fwd_w_only", bus.ForwardAE, 1);

    // x0 never forwards or stalls
    go(mk_alu(0, 1, 1), 0);
    go(mk_alu(2, 0, 0), 0);
    go(nop(), 0);
    check("x0_fwdb", bus.ForwardBE, 0);
    go(mk_load(0, 1), 0);
    go(mk_alu(2, 0, 0), 0);
    check("x0_nostall", bus.StallF, 0);

    // branch taken / not taken, jump
    go(mk_branch(1, 2), 0);
    go(nop(), 1);
    check("br_taken_pcsrc", bus.PCSrcE, 1);
    check("br_taken_flushd", bus.FlushD, 1);
    check("br_taken_flushe", bus.FlushE, 1);
    go(mk_branch(1, 2), 0);
    go(nop(), 0);
    check("br_not_taken", bus.PCSrcE, 0);
    go(mk_jump(1), 0);
    go(nop(), 0);
    check("jump_pcsrc", bus.PCSrcE, 1);

    // D->W latency is exactly three cycles
    repeat (3) go(nop(), 0);
    go(mk_jump(9), 0);
    go(nop(), 0);
    go(nop(), 0);
    check("lat_early_regw", bus.RegWriteW, 0);
    go(nop(), 0);
    check("lat_regw", bus.RegWriteW, 1);
    check("lat_rdw", bus.RdW, 9);
    check("lat_ressrcw", bus.ResultSrcW, 2);

    // asynchronous reset in the middle of a stall
    go(mk_load(5, 1), 0);
    go(mk_alu(6, 5, 0), 0);
    #2;
    check("rst_mid_pre_stall", bus.StallF, 1);
    reset = 1'b1;
    #1;
    check_zero("rst_mid");
    @(posedge clk);
    #3;
    reset = 1'b0;
    model_reset();
    go(mk_alu(6, 5, 5), 0);
    check("post_rst_nostall", bus.StallF, 0);

    // randomized traffic; D is held while the pipe stalls
    cur = rand_instr();
    for (int n = 0; n < 400; n++) begin
      issue(cur, 1'($urandom), st);
      if (!st) cur = rand_instr();
    end

    @(negedge clk);
    #3;
    check("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
